// File: rtl/fir_sequencer.sv
// rtl/fir_sequencer.sv - FIR pass sequencer: tap/sample walk, MAC strobes, output writes
module fir_sequencer #(
  parameter int ADDR_W  = 13,
  parameter int TAP_W   = 6,
  parameter int RAM_LAT = 1,
  parameter int MAC_LAT = 1
) (
  input  logic              a_clk,
  input  logic              a_rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic [TAP_W-1:0]  taps,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [TAP_W-1:0]  coef_addr,
  output logic              zero_sel,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              out_wr,
  output logic [ADDR_W-1:0] out_addr
);

  // Write pipe spans RAM read plus MAC latency; the MAC pipe only the RAM read.
  localparam int PIPE  = RAM_LAT + MAC_LAT;
  localparam int CMP_W = (ADDR_W > TAP_W) ? ADDR_W : TAP_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [TAP_W-1:0]  taps_q, taps_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [TAP_W-1:0]  k_q, k_d;

  // MAC-side pipe: valid, first tap, zero operand; RAM_LAT stages deep.
  logic [RAM_LAT-1:0] mv_q, mf_q, mz_q;
  // Write-side pipe: last-tap valid and its sample index; PIPE stages deep.
  logic [PIPE-1:0]             wv_q;
  logic [PIPE-1:0][ADDR_W-1:0] wn_q;

  logic              issue_v;
  logic              n_ge_k;
  logic              last_tap;
  logic              last_n;
  logic              final_wr;
  logic [CMP_W-1:0]  n_ext, k_ext;

  assign issue_v  = (state_q == S_RUN);
  assign n_ext    = CMP_W'(n_q);
  assign k_ext    = CMP_W'(k_q);
  assign n_ge_k   = (n_ext >= k_ext);
  assign last_tap = (k_q == taps_q - TAP_W'(1));
  assign last_n   = (n_q == len_q - ADDR_W'(1));

  // Issue-stage outputs are driven straight from the walk counters.
  assign rd_en     = issue_v & n_ge_k;
  assign rd_addr   = (issue_v && n_ge_k) ? (n_q - ADDR_W'(k_q)) : '0;
  assign coef_addr = issue_v ? k_q : '0;

  // Delayed outputs come from the final stage of each pipe.
  assign mac_en   = mv_q[RAM_LAT-1];
  assign mac_clr  = mv_q[RAM_LAT-1] & mf_q[RAM_LAT-1];
  assign zero_sel = mv_q[RAM_LAT-1] & mz_q[RAM_LAT-1];
  assign out_wr   = wv_q[PIPE-1];
  assign out_addr = wv_q[PIPE-1] ? wn_q[PIPE-1] : '0;
  assign final_wr = wv_q[PIPE-1] && (wn_q[PIPE-1] == len_q - ADDR_W'(1));

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  // State, latched pass configuration and tap/sample counters.
  always_ff @(posedge a_clk) begin
    if (!a_rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      taps_q  <= '0;
      n_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      taps_q  <= taps_d;
      n_q     <= n_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic: accept start only in IDLE, walk taps, drain, pulse done.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    taps_d  = taps_q;
    n_d     = n_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          taps_d  = taps;
          n_d     = '0;
          k_d     = '0;
          state_d = ((len == '0) || (taps == '0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_tap) begin
          k_d = '0;
          if (last_n) begin
            state_d = S_DRAIN;
          end else begin
            n_d = n_q + ADDR_W'(1);
          end
        end else begin
          k_d = k_q + TAP_W'(1);
        end
      end
      S_DRAIN: begin
        if (final_wr) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // MAC strobe pipe: aligns clear/enable/zero with data returning from RAM.
  always_ff @(posedge a_clk) begin
    if (!a_rst_n) begin
      mv_q <= '0;
      mf_q <= '0;
      mz_q <= '0;
    end else begin
      for (int i = RAM_LAT - 1; i > 0; i--) begin
        mv_q[i] <= mv_q[i-1];
        mf_q[i] <= mf_q[i-1];
        mz_q[i] <= mz_q[i-1];
      end
      mv_q[0] <= issue_v;
      mf_q[0] <= issue_v & (k_q == '0);
      mz_q[0] <= issue_v & ~n_ge_k;
    end
  end

  // Output-write pipe: carries the last tap of each sample through MAC latency.
  always_ff @(posedge a_clk) begin
    if (!a_rst_n) begin
      wv_q <= '0;
      wn_q <= '0;
    end else begin
      for (int i = PIPE - 1; i > 0; i--) begin
        wv_q[i] <= wv_q[i-1];
        wn_q[i] <= wn_q[i-1];
      end
      wv_q[0] <= issue_v & last_tap;
      wn_q[0] <= n_q;
    end
  end

endmodule

// File: doc/fir_sequencer.md
Name: fir_sequencer

Overview:
- Controller that runs one FIR filtering pass over the sample block already written into input RAM by the AXI slave.
- For each output sample n it walks taps k = 0..taps-1 at one tap per cycle. Per tap it issues an input-RAM read of x[n-k] and a coefficient address k.
- It drives the MAC clear/enable strobes aligned to returning data, and issues the output-RAM write for y[n].
- Sits between the AXI register/start logic and the MAC datapath; it owns the input-RAM read port and the output-RAM write port.

Parameters:
- ADDR_W, 13, width of sample index and input/output RAM addresses
- TAP_W, 6, width of tap count and coefficient address
- RAM_LAT, 1, input-RAM/coef-ROM read latency in cycles (>=1)
- MAC_LAT, 1, cycles from last mac_en to result valid at output-RAM data input (>=1)

Ports:
- a_clk  in  1  clock
- a_rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to begin a pass
- len  in  ADDR_W  number of output samples; sampled with start
- taps  in  TAP_W  number of taps; sampled with start
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass
- rd_en  out  1  input-RAM read strobe
- rd_addr  out  ADDR_W  input-RAM read address (n-k)
- coef_addr  out  TAP_W  coefficient address (k)
- zero_sel  out  1  forces the MAC data operand to 0; delayed RAM_LAT cycles, aligned with mac_en
- mac_clr  out  1  load the accumulator with the product instead of adding; aligned with mac_en of tap 0
- mac_en  out  1  MAC accumulate enable
- out_wr  out  1  output-RAM write strobe
- out_addr  out  ADDR_W  output-RAM write address (n)

Behaviour:
- Reset (a_rst_n=0 at a clock edge):
  - All outputs go to 0; state goes to IDLE; pipeline shift registers are cleared.
  - Reset mid-pass aborts the pass immediately. No further out_wr or done is produced.
- IDLE:
  - start=1 latches len and taps and clears n and k.
  - If len==0 or taps==0, go to DONE. Otherwise go to RUN.
  - start while busy=1 is ignored. It is not queued.
- RUN (one tap issued every cycle, no stalls):
  - Issue-stage outputs: rd_en=1 only when n>=k; rd_addr=n-k when n>=k, else 0; coef_addr=k.
  - The internal zero flag is (n<k). It is output as zero_sel after the RAM_LAT delay.
  - k increments each cycle. When k==taps-1, k returns to 0 and n increments.
  - The cycle issuing n==len-1, k==taps-1 is the last issue cycle; the next state is DRAIN.
  - No wrap of n past len-1. Arithmetic uses unsigned ADDR_W bits; the comparison n>=k is done at max(ADDR_W,TAP_W) bits.
- Pipeline (a shift register carries valid, first, last, zero, n):
  - mac_en, mac_clr (first = k==0) and zero_sel are asserted exactly RAM_LAT cycles after the issue cycle.
  - out_wr is asserted RAM_LAT+MAC_LAT cycles after the issue cycle with k==taps-1, with out_addr = that n.
  - out_addr is 0 when out_wr=0.
- DRAIN: waits until the final out_wr has been emitted, then goes to DONE.
- DONE:
  - done=1 for exactly one cycle, in the cycle after the final out_wr (or the cycle after start when len or taps is 0).
  - Next state is IDLE.
- busy:
  - =1 in every cycle the state is RUN, DRAIN or DONE. It goes high the cycle after start is accepted and low the cycle after done.
  - A start coincident with done is ignored; start is accepted from IDLE only.
- Total pass duration: len*taps issue cycles + RAM_LAT+MAC_LAT drain + 1 done cycle.

Test Plan:
- RAM_LAT=1, MAC_LAT=1; start at cycle 0 with len=3, taps=2:
  - Issue cycles 1..6 give rd_addr/zero flag (0,0),(0,zero),(1,0),(0,0),(2,0),(1,0) and coef_addr 0,1,0,1,0,1. rd_en=0 only at cycle 2.
  - mac_en at cycles 2..7; mac_clr at cycles 2,4,6; zero_sel at cycle 3.
  - out_wr at cycles 4,6,8 with out_addr 0,1,2; done at cycle 9; busy high cycles 1..9.
- len=0 or taps=0: start at cycle 0 -> busy=1 and done=1 at cycle 1. No rd_en, mac_en or out_wr ever asserted.
- len=1, taps=1: single issue at cycle 1 with rd_addr=0 -> mac_en and mac_clr at 2, out_wr addr 0 at 3, done at 4.
- start pulsed again at cycle 3 during the first pass -> ignored. The first pass completes unchanged and no second pass runs.
- a_rst_n=0 at cycle 4 of the scenario-1 run -> all outputs 0 from the next edge. No out_wr at 6 or 8, no done. A start after reset runs a clean pass.
- RAM_LAT=2, MAC_LAT=3, len=4, taps=8 -> 32 issue cycles. Each mac_en lags its issue by 2 cycles; each out_wr lags its k=7 issue by 5 cycles. out_addr sequence is 0..3.
